// File: rtl/keccak_pkg.sv
// keccak_pkg: shared Keccak types and rate constants.
//   keccak_mode_t   - hash/XOF mode selector (SHAKE128, SHAKE256, SHA3-256, SHA3-512)
//   tracker_state_t - absorb length tracker states
//   rate_words()    - rate of a mode expressed in lane-width words
package keccak_pkg;

  typedef enum logic [1:0] {
    MODE_SHAKE128 = 2'd0,
    MODE_SHAKE256 = 2'd1,
    MODE_SHA3_256 = 2'd2,
    MODE_SHA3_512 = 2'd3
  } keccak_mode_t;

  typedef enum logic [1:0] {
    TRK_IDLE   = 2'd0,
    TRK_ABSORB = 2'd1,
    TRK_PAD    = 2'd2,
    TRK_DONE   = 2'd3
  } tracker_state_t;

  localparam int unsigned RATE_BITS_1344 = 32'd1344;
  localparam int unsigned RATE_BITS_1088 = 32'd1088;
  localparam int unsigned RATE_BITS_576  = 32'd576;

  // Rate in words of w bits; w is always an elaboration-time constant.
  function automatic int unsigned rate_words(input keccak_mode_t mode, input int unsigned w);
    int unsigned rate_bits;
    case (mode)
      MODE_SHAKE128: rate_bits = RATE_BITS_1344;
      MODE_SHAKE256: rate_bits = RATE_BITS_1088;
      MODE_SHA3_256: rate_bits = RATE_BITS_1088;
      MODE_SHA3_512: rate_bits = RATE_BITS_576;
      default:       rate_bits = RATE_BITS_1344;
    endcase
    return rate_bits / w;
  endfunction

endpackage

// File: rtl/block_word_counter.sv
// block_word_counter: modulo-rate word position counter within a rate block.
//   clk, rst   - clock, synchronous active-high reset
//   clear      - force the index back to 0 (wins over inc)
//   inc        - advance one word, wrapping after rate_last
//   rate_last  - index of the last word in a block (rate_words-1)
//   word_idx   - current word index within the block
//   block_end  - word_idx equals rate_last
module block_word_counter #(
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [IDX_W-1:0] rate_last,
  output logic [IDX_W-1:0] word_idx,
  output logic             block_end
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  assign word_idx  = idx_q;
  assign block_end = (idx_q == rate_last);

  // Next index: clear, wrap at block end, or step.
  always_comb begin
    idx_d = idx_q;
    if (clear) begin
      idx_d = {IDX_W{1'b0}};
    end else if (inc) begin
      if (block_end) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= {IDX_W{1'b0}};
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/absorb_length_tracker.sv
// absorb_length_tracker: walks a message of length_in bits word by word and
// reports, per word, the valid bit count, block position and final-block /
// padding status for the absorb datapath.
//   clk, rst    - clock, synchronous active-high reset
//   start       - load length_in / mode_in and begin a message (any state)
//   length_in   - message length in bits
//   mode_in     - keccak_mode_t encoding
//   word_valid  - current word consumed this cycle
//   busy, done  - ABSORB/PAD, DONE
//   last_word   - current word is the final data word
//   word_bits   - valid data bits in the current word (0..W)
//   pad_word    - current word carries padding only
//   word_idx    - word index within the current block
//   block_end   - current word is the last of its block
//   last_block  - current block is the final absorbed block
// All outputs decode registered state only.
module absorb_length_tracker
  import keccak_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned W              = 64,
  parameter int unsigned MAX_RATE_WORDS = 1344 / W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [WIDTH-1:0]                  length_in,
  input  logic [1:0]                        mode_in,
  input  logic                              word_valid,
  output logic                              busy,
  output logic                              done,
  output logic                              last_word,
  output logic [$clog2(W):0]                word_bits,
  output logic                              pad_word,
  output logic [$clog2(MAX_RATE_WORDS)-1:0] word_idx,
  output logic                              block_end,
  output logic                              last_block
);

  localparam int unsigned IDX_W  = $clog2(MAX_RATE_WORDS);
  localparam int unsigned WB_W   = $clog2(W) + 1;
  localparam int unsigned LOG2W  = $clog2(W);
  localparam int unsigned RW_W   = IDX_W + 1;
  localparam int unsigned SPAN_W = RW_W + LOG2W;
  // Wide enough that neither the remaining count nor the block span truncates.
  localparam int unsigned CMP_W  = ((WIDTH > SPAN_W) ? WIDTH : SPAN_W) + 1;

  tracker_state_t   state_q, state_d;
  keccak_mode_t     mode_q, mode_d;
  logic [WIDTH-1:0] r_q, r_d;

  logic             cnt_clear_s;
  logic             cnt_inc_s;
  logic [IDX_W-1:0] cnt_idx_s;
  logic             cnt_end_s;
  logic [RW_W-1:0]  rate_words_s;
  logic [IDX_W-1:0] rate_last_s;

  logic             r_le_w_s;
  logic             r_lt_w_s;
  logic [WB_W-1:0]  data_bits_s;
  logic [CMP_W-1:0] span_bits_s;
  logic             data_last_block_s;
  logic [WIDTH-1:0] r_sat_s;

  assign rate_words_s = RW_W'(rate_words(mode_q, W));
  assign rate_last_s  = IDX_W'(rate_words_s - {{(RW_W-1){1'b0}}, 1'b1});

  block_word_counter #(
    .IDX_W (IDX_W)
  ) u_word_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear_s),
    .inc       (cnt_inc_s),
    .rate_last (rate_last_s),
    .word_idx  (cnt_idx_s),
    .block_end (cnt_end_s)
  );

  // Per-word arithmetic on the remaining-bits counter.
  always_comb begin
    r_le_w_s    = (r_q <= WIDTH'(W));
    r_lt_w_s    = (r_q < WIDTH'(W));
    // A full last word reports W, so the count is never taken modulo W.
    data_bits_s = r_lt_w_s ? r_q[WB_W-1:0] : WB_W'(W);
    // Bits still available in this block: (rate_words - word_idx) * W.
    span_bits_s = CMP_W'(rate_words_s - RW_W'(cnt_idx_s)) << LOG2W;
    // Strict: a message exactly filling the block still needs a pad block.
    data_last_block_s = (CMP_W'(r_q) < span_bits_s);
    r_sat_s     = r_lt_w_s ? {WIDTH{1'b0}} : (r_q - WIDTH'(W));
  end

  // Next-state logic; start overrides any handshake in the same cycle.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    r_d         = r_q;
    cnt_clear_s = 1'b0;
    cnt_inc_s   = 1'b0;
    if (start) begin
      state_d     = TRK_ABSORB;
      mode_d      = keccak_mode_t'(mode_in);
      r_d         = length_in;
      cnt_clear_s = 1'b1;
    end else begin
      case (state_q)
        TRK_ABSORB: begin
          if (word_valid) begin
            r_d       = r_sat_s;
            cnt_inc_s = 1'b1;
            if (r_le_w_s) begin
              // A short last word at block end leaves room for the padding.
              if (cnt_end_s && r_lt_w_s) begin
                state_d = TRK_DONE;
              end else begin
                state_d = TRK_PAD;
              end
            end else begin
              state_d = TRK_ABSORB;
            end
          end else begin
            state_d = TRK_ABSORB;
          end
        end
        TRK_PAD: begin
          if (word_valid) begin
            cnt_inc_s = 1'b1;
            if (cnt_end_s) begin
              state_d = TRK_DONE;
            end else begin
              state_d = TRK_PAD;
            end
          end else begin
            state_d = TRK_PAD;
          end
        end
        TRK_DONE: state_d = TRK_DONE;
        TRK_IDLE: state_d = TRK_IDLE;
        default:  state_d = TRK_IDLE;
      endcase
    end
  end

  // Moore output decode.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    last_word  = 1'b0;
    word_bits  = {WB_W{1'b0}};
    pad_word   = 1'b0;
    word_idx   = {IDX_W{1'b0}};
    block_end  = 1'b0;
    last_block = 1'b0;
    case (state_q)
      TRK_ABSORB: begin
        busy       = 1'b1;
        last_word  = r_le_w_s;
        word_bits  = data_bits_s;
        word_idx   = cnt_idx_s;
        block_end  = cnt_end_s;
        last_block = data_last_block_s;
      end
      TRK_PAD: begin
        busy       = 1'b1;
        pad_word   = 1'b1;
        word_idx   = cnt_idx_s;
        block_end  = cnt_end_s;
        last_block = 1'b1;
      end
      TRK_DONE: done = 1'b1;
      TRK_IDLE: done = 1'b0;
      default:  done = 1'b0;
    endcase
  end

  // State, mode and remaining-bits registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TRK_IDLE;
      mode_q  <= MODE_SHAKE128;
      r_q     <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      r_q     <= r_d;
    end
  end

endmodule

// File: tb/tb_absorb_length_tracker.sv
module tb_absorb_length_tracker;

  localparam int WIDTH = 32;
  localparam int W     = 64;
  localparam int MRW   = 1344 / W;
  localparam int IDX_W = $clog2(MRW);
  localparam int WB_W  = $clog2(W) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] length_in;
  logic [1:0]       mode_in;
  logic             word_valid;
  logic             busy, done, last_word, pad_word, block_end, last_block;
  logic [WB_W-1:0]  word_bits;
  logic [IDX_W-1:0] word_idx;

  int n_vec = 0;
  int n_bad = 0;
  int rate_tbl [4] = '{1344 / W, 1088 / W, 1088 / W, 576 / W};
  int deltas   [6] = '{-64, -1, 0, 1, 63, 64};

  always #5 clk = ~clk;

  absorb_length_tracker #(.WIDTH(WIDTH), .W(W), .MAX_RATE_WORDS(MRW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .length_in  (length_in),
    .mode_in    (mode_in),
    .word_valid (word_valid),
    .busy       (busy),
    .done       (done),
    .last_word  (last_word),
    .word_bits  (word_bits),
    .pad_word   (pad_word),
    .word_idx   (word_idx),
    .block_end  (block_end),
    .last_block (last_block)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (busy,done,lw,pad,bend,lblk,bits,idx)", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input bit b, input bit d, input bit lw, input bit pw,
                                       input bit be, input bit lb, input int bits, input int idx);
    logic [WB_W-1:0]  bits_v;
    logic [IDX_W-1:0] idx_v;
    bits_v = WB_W'(bits);
    idx_v  = IDX_W'(idx);
    return {14'd0, b, d, lw, pw, be, lb, bits_v, idx_v};
  endfunction

  function automatic logic [31:0] obs();
    return {14'd0, busy, done, last_word, pad_word, block_end, last_block, word_bits, word_idx};
  endfunction

  // Reference: message of len bits occupies d data words; padding needs at
  // least one bit after the data, and the stream ends on a block boundary.
  function automatic int data_words(input int len);
    return (len == 0) ? 1 : (len + W - 1) / W;
  endfunction

  function automatic int total_words(input int len, input int rate);
    int d, b;
    d = data_words(len);
    b = len - (d - 1) * W;
    if (d % rate == 0) return (b == W) ? d + rate : d;
    return ((d + rate - 1) / rate) * rate;
  endfunction

  function automatic logic [31:0] exp_word(input int len, input int rate, input int k);
    int d, b, t, idx;
    bit lb;
    d   = data_words(len);
    b   = len - (d - 1) * W;
    t   = total_words(len, rate);
    idx = k % rate;
    lb  = ((k / rate) == ((t - 1) / rate));
    if (k < d) return pack(1, 0, k == d - 1, 0, idx == rate - 1, lb, (k == d - 1) ? b : W, idx);
    return pack(1, 0, 0, 1, idx == rate - 1, 1, 0, idx);
  endfunction

  // Called at a falling edge; returns at a falling edge with inputs idle.
  task automatic run_msg(input int len, input int mode, input int stop_after,
                         input bit wv_at_start, input int gap_pct);
    int rate, t, k, cyc;
    bit wv;
    rate = rate_tbl[mode];
    t    = total_words(len, rate);
    k    = 0;
    cyc  = 0;
    start      = 1'b1;
    length_in  = WIDTH'(len);
    mode_in    = 2'(mode);
    word_valid = wv_at_start;
    @(posedge clk); @(negedge clk);
    start      = 1'b0;
    word_valid = 1'b0;
    while (k < t && k != stop_after && cyc < 4000) begin
      check_val($sformatf("m%0d_len%0d_w%0d", mode, len, k), obs(), exp_word(len, rate, k));
      wv = ($urandom_range(99) >= gap_pct);
      word_valid = wv;
      @(posedge clk); @(negedge clk);
      word_valid = 1'b0;
      if (wv) k++;
      cyc++;
    end
    if (stop_after < 0) begin
      if (k < t) begin
        check_val($sformatf("timeout_m%0d_len%0d", mode, len), 32'(k), 32'(t));
      end else begin
        check_val($sformatf("done_m%0d_len%0d", mode, len), obs(), pack(0, 1, 0, 0, 0, 0, 0, 0));
        word_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        word_valid = 1'b0;
        check_val($sformatf("hold_m%0d_len%0d", mode, len), obs(), pack(0, 1, 0, 0, 0, 0, 0, 0));
      end
    end
  endtask

  initial begin
    int m, sel, len, rate;
    rst = 1'b1; start = 1'b1; word_valid = 1'b1; length_in = 32'd5; mode_in = 2'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset", obs(), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); @(negedge clk);
    word_valid = 1'b0;
    check_val("idle_ignores_wv", obs(), 32'd0);

    run_msg(100, 0, -1, 1'b0, 0);
    run_msg(1344, 0, -1, 1'b0, 30);
    run_msg(0, 3, -1, 1'b0, 0);
    run_msg(64, 2, -1, 1'b0, 0);
    run_msg(2000, 1, 5, 1'b0, 0);
    run_msg(8, 1, -1, 1'b1, 0);

    // Reset while padding, with start and word_valid asserted.
    run_msg(100, 0, 5, 1'b0, 0);
    rst = 1'b1; start = 1'b1; word_valid = 1'b1; length_in = 32'd999; mode_in = 2'd1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; start = 1'b0; word_valid = 1'b0;
    check_val("rst_in_pad", obs(), 32'd0);
    run_msg(64, 2, -1, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      m    = $urandom_range(3);
      rate = rate_tbl[m];
      sel  = $urandom_range(2);
      if (sel == 0)      len = $urandom_range(200);
      else if (sel == 1) len = rate * W * $urandom_range(1, 2) + deltas[$urandom_range(5)];
      else               len = $urandom_range(3 * rate * W);
      run_msg(len, m, -1, 1'b0, 25);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
